// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: captures one 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in place, then presents the result until the consumer takes it.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // For COLS_PER_CYCLE=4 the step truncates to 0: one CALC cycle, counter stays 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [6:0]   col_lsb;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int r = 0; r < 4; r++) begin
      s[r]  = col[31-8*r -: 8];
      x2[r] = xtime(s[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ s[r];
      mb[r] = x8[r] ^ x2[r] ^ s[r];
      md[r] = x8[r] ^ x4[r] ^ s[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column c lives at bit offset (3-c)*32, and 3-c equals ~c for a 2-bit index.
  always_comb begin
    work_d  = work_q;
    col_lsb = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_lsb = {~(cnt_q + 2'(j)), 5'd0};
      work_d[col_lsb +: 32] = inv_col(work_q[col_lsb +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in_data;
            cnt_q      <= '0;
            state_q    <= S_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_CALC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_STEP;
          if (cnt_q == LAST_CNT) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_q       <= work_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: three instances (1, 2, 4 columns per cycle) checked
// every cycle against a GF(2^8) matrix model with handshake/latency expectations.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix rows {0e,0b,0d,09} rotated by the output row index.
  function automatic logic [127:0] model_inv_mix(input logic [127:0] st);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], st[127 - 32*c - 8*k -: 8]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    return res;
  endfunction

  function automatic int lat(input int g);
    return 4 >> g;
  endfunction

  logic [127:0] exp_q [3][$];
  bit           inflight [3];
  int           acc_cyc  [3];
  logic [127:0] last_out [3];
  int           hs_log [$];

  initial begin
    for (int g = 0; g < 3; g++) begin
      inflight[g] = 1'b0;
      acc_cyc[g]  = 0;
      last_out[g] = '0;
    end
  end

  // Compare process: every negedge, for every instance.
  always @(negedge clk) begin
    bit was_inflight;
    bit ov_exp;
    for (int g = 0; g < 3; g++) begin
      if (!rst) begin
        chk("rst_in_ready", in_ready[g], 1);
        chk("rst_out_valid", out_valid[g], 0);
        chk("rst_busy", busy[g], 0);
        chk("rst_out_data", out_data[g], 0);
        inflight[g] = 1'b0;
        last_out[g] = '0;
        exp_q[g].delete();
      end else begin
        was_inflight = inflight[g];
        ov_exp = inflight[g] && (cyc - acc_cyc[g] >= 1 + lat(g));
        chk("in_ready", in_ready[g], !inflight[g]);
        chk("busy", busy[g], inflight[g]);
        chk("out_valid", out_valid[g], ov_exp);
        if (ov_exp) begin
          chk("out_data", out_data[g], exp_q[g][0]);
          if (out_ready[g]) begin
            last_out[g] = exp_q[g].pop_front();
            inflight[g] = 1'b0;
            if (g == 0) hs_log.push_back(cyc);
          end
        end else begin
          chk("out_data_hold", out_data[g], last_out[g]);
        end
        if (in_valid[g] && !was_inflight) begin
          exp_q[g].push_back(model_inv_mix(in_data[g]));
          inflight[g] = 1'b1;
          acc_cyc[g]  = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int g, input logic [127:0] d);
    bit got = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready[g]) begin got = 1; break; end
    end
    chk("send_accept_timeout", got, 1);
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (!inflight[g]) begin got = 1; break; end
    end
    chk("wait_idle_timeout", got, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] v1, r1, v2, r2, ones, zero;
  logic [127:0] b2b [3];

  initial begin
    v1   = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    r1   = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    v2   = 128'h4d7ebdf8_8e4da1bc_c6c6c6c6_9fdc589d;
    r2   = 128'h2d26314c_db135345_c6c6c6c6_f20a225c;
    ones = 128'h01010101_01010101_01010101_01010101;
    zero = '0;
    b2b[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    b2b[1] = v1;
    b2b[2] = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;

    // Pin the model to hand-known results.
    chk("model_v1", model_inv_mix(v1), r1);
    chk("model_v2", model_inv_mix(v2), r2);
    chk("model_ones", model_inv_mix(ones), ones);
    chk("model_zero", model_inv_mix(zero), zero);

    in_valid  = '0;
    out_ready = '1;
    for (int g = 0; g < 3; g++) in_data[g] = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single state, one column per cycle.
    send(0, v1);
    wait_idle(0);

    // Round trip on every width.
    for (int g = 0; g < 3; g++) begin
      send(g, v2);
      wait_idle(g);
    end

    // All-zero input.
    send(0, zero);
    wait_idle(0);

    // Backpressure with a stray in_valid during DONE.
    out_ready[0] = 1'b0;
    send(0, v2);
    repeat (7) @(posedge clk);
    #1 in_valid[0] = 1'b1;
    in_data[0] = v1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_idle(0);

    // Back-to-back with in_valid held high.
    hs_log.delete();
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit got = 0;
      in_data[0] = b2b[i];
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready[0]) begin got = 1; break; end
      end
      chk("b2b_accept_timeout", got, 1);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    chk("b2b_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("b2b_gap0", hs_log[1] - hs_log[0], 6);
      chk("b2b_gap1", hs_log[2] - hs_log[1], 6);
    end

    // Asynchronous reset two cycles into CALC.
    send(0, v1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_in_ready", in_ready[0], 1);
    chk("async_out_valid", out_valid[0], 0);
    chk("async_busy", busy[0], 0);
    chk("async_out_data", out_data[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(0, ones);
    wait_idle(0);
    chk("post_reset_last", last_out[0], ones);

    repeat (3) @(posedge clk);
    chk("queues_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
Iterative AES InvMixColumns stage for the decryption datapath. It is the inverse of the existing registered MixColumns block. It accepts one 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock through shared GF(2^8) multiply logic. It returns the result through a valid/ready handshake, sitting between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is a synthesis error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a state
in_data  input  128  state; column c = bits [127-32c : 96-32c]; byte r of column c = bits [127-32c-8r : 120-32c-8r]
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
out_data  output  128  InvMixColumns(state), same byte layout
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal state/column counter=0.
- Per-column math over GF(2^8), polynomial 0x11B. For column bytes s0..s3:
  - o0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - o1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - o2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - o3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
  - Build from xtime chains; no lookup tables.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the working register, clear the column counter, go to CALC.
  - CALC: in_ready=0. Each cycle, transform columns cnt..cnt+COLS_PER_CYCLE-1 in place, then cnt += COLS_PER_CYCLE. After the cycle that writes column 3, go to DONE.
  - DONE: out_valid=1, out_data = working register, held stable until out_ready. On out_valid&out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: 4/COLS_PER_CYCLE CALC cycles (4, 2 or 1). out_valid rises on the cycle after the last CALC cycle. Accept-to-out_valid is 4/2/1 clocks after the accepting edge.
- No overlap: in_ready is 0 in CALC and DONE. in_valid is ignored there, with no capture and no error. A new state is accepted only in IDLE, earliest the cycle after the output handshake. Throughput is one state per 4/COLS_PER_CYCLE+2 cycles when out_ready is held high.
- Backpressure: out_ready low in DONE holds out_valid and out_data unchanged indefinitely.
- Column counter is 2 bits and wraps 3→0 only on leaving CALC. It never wraps while inside CALC.
- Reset mid-operation (CALC or DONE): everything returns immediately to reset values and the partial result is discarded. The first post-reset handshake behaves normally.
- out_data is undefined-free: it is 0 until the first result, then holds the last working-register contents outside DONE.

Test Plan:
- Single state, COLS_PER_CYCLE=1: in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6, out_ready=1 → out_valid rises 4 clocks after accept, out_data=db135345_f20a225c_01010101_d4d4d4d5, one-cycle pulse.
- Round trip: in_data=4d7ebdf8_8e4da1bc_c6c6c6c6_9fdc589d → out_data=2d26314c_db135345_c6c6c6c6_f20a225c. Repeat at COLS_PER_CYCLE=2 and 4; latency must be 2 and 1 clocks with identical data.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_data stable, in_ready=0, and a second in_valid pulse is not captured. Raise out_ready → handshake completes, and in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 3 distinct states and out_ready=1 → outputs appear in order, spaced 6 cycles apart (COLS_PER_CYCLE=1), each correct.
- Async reset: assert rst low 2 cycles into CALC, asynchronous to clk → out_valid=0, busy=0, in_ready=1 immediately. After release, a fresh state 01010101_01010101_01010101_01010101 returns the same value.
- Zero/identity: all-zero input → all-zero output after 4 clocks.
